// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream frame arbiter.
// Imported by the arbiter top and its beat counter.
package axis_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int SRC_W = 1;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_beat_counter.sv
// Beat counter for fixed-length frames.
// Wraps to zero on the last beat; clr has priority over inc.
module axis_beat_counter
  import axis_pkg::*;
#(
  parameter  int FRAME_WORDS = 512,
  localparam int CW          = clog2_min1(FRAME_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          at_last
);

  localparam logic [CW-1:0] LAST = CW'(FRAME_WORDS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign at_last = (cnt_q == LAST);
  assign cnt     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter for two AXI-Stream sources.
// Grants whole FRAME_WORDS-beat frames and regenerates TLAST.
module axis_frame_arbiter
  import axis_pkg::*;
#(
  parameter int TDATA_W     = 32,
  parameter int FRAME_WORDS = 512,
  parameter int CNT_W       = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic [TDATA_W-1:0]   s0_axis_tdata,
  input  logic [TDATA_W/8-1:0] s0_axis_tkeep,
  input  logic                 s0_axis_tvalid,
  output logic                 s0_axis_tready,
  input  logic                 s0_axis_tlast,
  input  logic [TDATA_W-1:0]   s1_axis_tdata,
  input  logic [TDATA_W/8-1:0] s1_axis_tkeep,
  input  logic                 s1_axis_tvalid,
  output logic                 s1_axis_tready,
  input  logic                 s1_axis_tlast,
  output logic [TDATA_W-1:0]   m_axis_tdata,
  output logic [TDATA_W/8-1:0] m_axis_tkeep,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tid,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int BW = clog2_min1(FRAME_WORDS);

  state_e           state_q;
  logic [SRC_W-1:0] grant_q;
  logic [SRC_W-1:0] rr_ptr_q;
  logic [SRC_W-1:0] winner;
  logic             frame_done_q;
  logic [CNT_W-1:0] frame_cnt_q;

  logic [BW-1:0]    beat_cnt;
  logic             at_last;
  logic             in_xfer;
  logic             sel1;
  logic             src_valid;
  logic             xfer;
  logic             unused_in;

  assign in_xfer   = (state_q == XFER);
  assign sel1      = grant_q[0];
  assign src_valid = sel1 ? s1_axis_tvalid : s0_axis_tvalid;

  assign m_axis_tdata  = sel1 ? s1_axis_tdata : s0_axis_tdata;
  assign m_axis_tkeep  = sel1 ? s1_axis_tkeep : s0_axis_tkeep;
  assign m_axis_tvalid = in_xfer & src_valid;
  assign m_axis_tlast  = m_axis_tvalid & at_last;
  assign m_axis_tid    = grant_q[0];

  assign s0_axis_tready = in_xfer & ~sel1 & m_axis_tready;
  assign s1_axis_tready = in_xfer &  sel1 & m_axis_tready;

  assign xfer       = m_axis_tvalid & m_axis_tready;
  assign busy       = in_xfer;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

  // Source TLAST is deliberately dropped; framing is by beat count.
  assign unused_in = ^{s0_axis_tlast, s1_axis_tlast, beat_cnt};

  assign winner = (s0_axis_tvalid & s1_axis_tvalid) ? rr_ptr_q
                : SRC_W'(s1_axis_tvalid);

  axis_beat_counter #(
    .FRAME_WORDS(FRAME_WORDS)
  ) u_beat_cnt (
    .clk    (aclk),
    .rst_n  (aresetn),
    .inc    (xfer),
    .clr    (~in_xfer),
    .cnt    (beat_cnt),
    .at_last(at_last)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (enable && (s0_axis_tvalid || s1_axis_tvalid)) begin
            grant_q <= winner;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (xfer && at_last) begin
            rr_ptr_q     <= ~grant_q;
            frame_cnt_q  <= frame_cnt_q + CNT_W'(1);
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Self-checking bench for axis_frame_arbiter (FRAME_WORDS=4, CNT_W=2).
// Frame-level reference model plus per-source data scoreboards.
module tb_axis_frame_arbiter;

  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int FW = 4;
  localparam int CW = 2;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] s0_tdata = '0;
  logic [KW-1:0] s0_tkeep = '0;
  logic          s0_tvalid = 1'b0;
  logic          s0_tready;
  logic          s0_tlast = 1'b0;
  logic [DW-1:0] s1_tdata = '0;
  logic [KW-1:0] s1_tkeep = '0;
  logic          s1_tvalid = 1'b0;
  logic          s1_tready;
  logic          s1_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          m_tid;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] frame_cnt;

  axis_frame_arbiter #(
    .TDATA_W(DW), .FRAME_WORDS(FW), .CNT_W(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep),
    .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
    .s0_axis_tlast(s0_tlast),
    .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep),
    .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
    .s1_axis_tlast(s1_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  // stimulus knobs
  bit en;
  bit [1:0] v;
  bit mrdy;
  int seq [2];

  // reference model: frame in flight, its owner, beats so far
  bit mb, md;
  int mg, mbeats, mcnt, mpref;
  int frames, accepted;
  int grants[$];

  // observations of DUT
  int dut_acc, dut_done, dut_lasts;
  int done_cnts[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input int s, input int q);
    return {8'(8'hA0 + s), 8'h5C, 16'(q)};
  endfunction

  function automatic logic [KW-1:0] mkkeep(input int s, input int q);
    return KW'((q * 5 + s * 3) & 15);
  endfunction

  task automatic mreset();
    mb = 0; md = 0; mg = 0; mbeats = 0; mcnt = 0; mpref = 0;
  endtask

  task automatic pre();
    bit ev, el;
    bit [1:0] er;
    enable    = en;
    m_tready  = mrdy;
    s0_tvalid = v[0];
    s1_tvalid = v[1];
    s0_tdata  = mkdata(0, seq[0]);
    s1_tdata  = mkdata(1, seq[1]);
    s0_tkeep  = mkkeep(0, seq[0]);
    s1_tkeep  = mkkeep(1, seq[1]);
    s0_tlast  = 1'($urandom_range(0, 1));
    s1_tlast  = 1'($urandom_range(0, 1));
    #1;
    ev    = mb && v[mg];
    er[0] = mb && mg == 0 && mrdy;
    er[1] = mb && mg == 1 && mrdy;
    el    = ev && mbeats == FW - 1;
    chk("busy", busy, mb);
    chk("m_tvalid", m_tvalid, ev);
    chk("s0_tready", s0_tready, er[0]);
    chk("s1_tready", s1_tready, er[1]);
    chk("m_tlast", m_tlast, el);
    chk("m_tid", m_tid, mg);
    chk("frame_done", frame_done, md);
    chk("frame_cnt", frame_cnt, mcnt);
    if (ev) begin
      chk("m_tdata", m_tdata, mkdata(mg, seq[mg]));
      chk("m_tkeep", m_tkeep, mkkeep(mg, seq[mg]));
    end
    if (m_tvalid && m_tready) dut_acc++;
    if (m_tvalid && m_tready && m_tlast) dut_lasts++;
    if (frame_done) begin
      dut_done++;
      done_cnts.push_back(int'(frame_cnt));
    end
  endtask

  task automatic post();
    bit ev;
    ev = mb && v[mg];
    @(posedge aclk);
    md = 0;
    if (!mb) begin
      if (en && v != 2'b00) begin
        mg = (v == 2'b11) ? mpref : (v[1] ? 1 : 0);
        mb = 1;
        grants.push_back(mg);
      end
    end else if (ev && mrdy) begin
      seq[mg]++;
      accepted++;
      mbeats++;
      if (mbeats == FW) begin
        mbeats = 0;
        mb     = 0;
        md     = 1;
        mcnt   = (mcnt + 1) % (1 << CW);
        mpref  = 1 - mg;
        frames++;
      end
    end
    #2;
  endtask

  task automatic tick();
    pre();
    post();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    mreset();
    en = 0; v = 0; mrdy = 0;
    frames = 0; accepted = 0;
    dut_acc = 0; dut_done = 0; dut_lasts = 0;
    grants.delete();
    done_cnts.delete();
    repeat (2) @(posedge aclk);
    #2;
    aresetn = 1'b1;
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting, got none expected event", nm);
  endtask

  typedef struct {
    bit en, v0, v1, rdy;
    bit e_busy, e_tv, e_r0, e_r1;
  } vec_t;

  vec_t vt [7];

  initial begin
    int f0, g, c;
    int exp_rr [4];
    int exp_wrap [5];
    exp_rr   = '{0, 1, 0, 1};
    exp_wrap = '{1, 2, 3, 0, 1};
    seq[0] = 0;
    seq[1] = 0;

    vt[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{0, 1, 0, 1, 0, 0, 0, 0};
    vt[2] = '{0, 0, 1, 1, 0, 0, 0, 0};
    vt[3] = '{0, 1, 1, 1, 0, 0, 0, 0};
    vt[4] = '{1, 1, 0, 0, 0, 0, 0, 0};
    vt[5] = '{0, 1, 0, 1, 1, 1, 1, 0};
    vt[6] = '{0, 0, 1, 1, 1, 0, 1, 0};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      en = vt[i].en; v = {vt[i].v1, vt[i].v0}; mrdy = vt[i].rdy;
      pre();
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("vec%0d_tvalid", i), m_tvalid, vt[i].e_tv);
      chk($sformatf("vec%0d_r0", i), s0_tready, vt[i].e_r0);
      chk($sformatf("vec%0d_r1", i), s1_tready, vt[i].e_r1);
      post();
    end

    // 1: single source, two back-to-back frames
    do_reset();
    en = 1; v = 2'b01; mrdy = 1;
    c = 0;
    while (frames < 2 && c < 40) begin tick(); c++; end
    if (frames < 2) timeout("t1_frames");
    pre();
    chk("t1_frame_cnt", frame_cnt, 2);
    chk("t1_done_pulses", dut_done, 2);
    chk("t1_beats", dut_acc, 8);
    chk("t1_tlasts", dut_lasts, 2);
    post();

    // 2: contention, strict alternation
    do_reset();
    en = 1; v = 2'b11; mrdy = 1;
    c = 0;
    while (frames < 4 && c < 60) begin tick(); c++; end
    if (frames < 4) timeout("t2_frames");
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_grant%0d", i),
          (grants.size() > i) ? grants[i] : -1, exp_rr[i]);

    // 3: random valid and backpressure
    do_reset();
    en = 1;
    for (int i = 0; i < 400; i++) begin
      v[0] = ($urandom_range(0, 3) != 0);
      v[1] = ($urandom_range(0, 3) != 0);
      mrdy = 1'($urandom_range(0, 1));
      tick();
    end
    chk("t3_accepted", dut_acc, accepted);
    chk("t3_tlasts", dut_lasts, frames);

    // 4: enable drops mid-frame
    do_reset();
    en = 1; v = 2'b11; mrdy = 1;
    c = 0;
    while (!(mb && mbeats == 2) && c < 20) begin tick(); c++; end
    if (!(mb && mbeats == 2)) timeout("t4_midframe");
    en = 0;
    g = mg;
    f0 = frames;
    c = 0;
    while (frames == f0 && c < 20) begin tick(); c++; end
    if (frames == f0) timeout("t4_finish");
    repeat (5) tick();
    pre();
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_r0", s0_tready, 0);
    chk("t4_idle_r1", s1_tready, 0);
    post();
    en = 1;
    tick();
    pre();
    chk("t4_next_tid", m_tid, 1 - g);
    post();

    // 5: reset in the middle of a frame
    do_reset();
    en = 1; v = 2'b01; mrdy = 1;
    c = 0;
    while (!(mb && mbeats == 3) && c < 20) begin tick(); c++; end
    if (!(mb && mbeats == 3)) timeout("t5_midframe");
    aresetn = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_tvalid", m_tvalid, 0);
    chk("t5_tlast", m_tlast, 0);
    chk("t5_r0", s0_tready, 0);
    chk("t5_tid", m_tid, 0);
    chk("t5_cnt", frame_cnt, 0);
    mreset();
    grants.delete();
    @(posedge aclk);
    #2;
    aresetn = 1'b1;
    f0 = frames;
    c = 0;
    while (frames == f0 && c < 20) begin tick(); c++; end
    if (frames == f0) timeout("t5_frame");
    chk("t5_grant", (grants.size() > 0) ? grants[0] : -1, 0);
    pre();
    chk("t5_cnt_after", frame_cnt, 1);
    post();

    // 6: frame counter wrap with CNT_W=2
    do_reset();
    en = 1; v = 2'b10; mrdy = 1;
    c = 0;
    while (done_cnts.size() < 5 && c < 60) begin tick(); c++; end
    if (done_cnts.size() < 5) timeout("t6_frames");
    for (int i = 0; i < 5; i++)
      chk($sformatf("t6_cnt%0d", i),
          (done_cnts.size() > i) ? done_cnts[i] : -1, exp_wrap[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
